// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch-side, data-side and backend memory signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the view of the stages and backend model.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  // fetch side
  logic            i_req;
  logic [AW-1:0]   i_addr;
  logic [DW-1:0]   i_rdata;
  logic            i_valid;

  // data side
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic [DW-1:0]   d_rdata;
  logic            d_valid;

  // hazard-unit stall requests
  logic            stall_i;
  logic            stall_d;

  // backend memory port
  logic            m_req;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_be;
  logic            m_gnt;
  logic            m_rvalid;
  logic [DW-1:0]   m_rdata;

  logic            busy;

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_valid,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_rdata, d_valid,
    output stall_i, stall_d,
    output m_req, m_we, m_addr, m_wdata, m_be,
    input  m_gnt, m_rvalid, m_rdata,
    output busy
  );

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_valid,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_rdata, d_valid,
    input  stall_i, stall_d,
    input  m_req, m_we, m_addr, m_wdata, m_be,
    output m_gnt, m_rvalid, m_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between MIPS fetch (read-only) and memory stage (read/write).
// One backend transaction at a time; D wins by default, I wins a tie right after a D completion.
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input logic          clk,
  input logic          resetn,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t          state;
  logic            ownD;
  logic            lastD;
  logic            iValidQ;
  logic            dValidQ;
  logic [DW-1:0]   iRdataQ;
  logic [DW-1:0]   dRdataQ;
  logic            mReqQ;
  logic            mWeQ;
  logic [AW-1:0]   mAddrQ;
  logic [DW-1:0]   mWdataQ;
  logic [DW/8-1:0] mBeQ;

  logic            iCand;
  logic            dCand;
  logic            grantD;
  logic            grantI;

  // A side still holding req during its own valid pulse must not be granted again.
  always_comb begin
    iCand  = bus.i_req & ~iValidQ;
    dCand  = bus.d_req & ~dValidQ;
    grantD = dCand & ~(iCand & lastD);
    grantI = iCand & ~grantD;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      ownD    <= 1'b0;
      lastD   <= 1'b0;
      iValidQ <= 1'b0;
      dValidQ <= 1'b0;
      iRdataQ <= '0;
      dRdataQ <= '0;
      mReqQ   <= 1'b0;
      mWeQ    <= 1'b0;
      mAddrQ  <= '0;
      mWdataQ <= '0;
      mBeQ    <= '0;
    end else begin
      iValidQ <= 1'b0;
      dValidQ <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grantD) begin
            state   <= S_REQ;
            mReqQ   <= 1'b1;
            ownD    <= 1'b1;
            mWeQ    <= bus.d_we;
            mAddrQ  <= bus.d_addr;
            mWdataQ <= bus.d_wdata;
            mBeQ    <= bus.d_be;
          end else if (grantI) begin
            state   <= S_REQ;
            mReqQ   <= 1'b1;
            ownD    <= 1'b0;
            mWeQ    <= 1'b0;
            mAddrQ  <= bus.i_addr;
            mWdataQ <= '0;
            mBeQ    <= '1;
          end
        end
        S_REQ: begin
          if (bus.m_gnt) begin
            state <= S_WAIT;
            mReqQ <= 1'b0;
          end
        end
        S_WAIT: begin
          // Completion is delivered even if the owner dropped req; the stage discards it.
          if (bus.m_rvalid) begin
            state <= S_IDLE;
            lastD <= ownD;
            if (ownD) begin
              dRdataQ <= bus.m_rdata;
              dValidQ <= 1'b1;
            end else begin
              iRdataQ <= bus.m_rdata;
              iValidQ <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.i_rdata = iRdataQ;
  assign bus.i_valid = iValidQ;
  assign bus.d_rdata = dRdataQ;
  assign bus.d_valid = dValidQ;
  assign bus.stall_i = bus.i_req & ~iValidQ;
  assign bus.stall_d = bus.d_req & ~dValidQ;
  assign bus.m_req   = mReqQ;
  assign bus.m_we    = mWeQ;
  assign bus.m_addr  = mAddrQ;
  assign bus.m_wdata = mWdataQ;
  assign bus.m_be    = mBeQ;
  assign bus.busy    = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single load, contention, backpressure,
// killed fetch and reset during an outstanding transaction.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Each call leaves us 1 time unit after a rising edge: the "current cycle".
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.i_req    = 1'b0;
    bus.i_addr   = '0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.d_be     = '0;
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rdata  = '0;
  endtask

  task automatic test_reset;
    clear_inputs();
    resetn = 1'b0;
    tick();
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%h exp=0", bus.busy); end
    total++; if (bus.m_req !== 1'b0) begin bad++; $display("FAIL rst_mreq got=%h exp=0", bus.m_req); end
    total++; if (bus.m_addr !== 32'h0 || bus.m_wdata !== 32'h0) begin bad++; $display("FAIL rst_maddr_wdata got=%h/%h exp=0/0", bus.m_addr, bus.m_wdata); end
    total++; if (bus.m_be !== 4'h0 || bus.m_we !== 1'b0) begin bad++; $display("FAIL rst_mbe_we got=%h/%h exp=0/0", bus.m_be, bus.m_we); end
    total++; if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0/0", bus.i_rdata, bus.d_rdata); end
    resetn = 1'b1;
    tick();
    total++; if (bus.i_valid !== 1'b0 || bus.d_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h/%h exp=0/0", bus.i_valid, bus.d_valid); end
    total++; if (bus.stall_i !== 1'b0 || bus.stall_d !== 1'b0) begin bad++; $display("FAIL rst_stall got=%h/%h exp=0/0", bus.stall_i, bus.stall_d); end
    // stray backend response while idle
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'hFFFF0000;
    tick();
    bus.m_rvalid = 1'b0;
    tick();
    total++; if (bus.i_valid !== 1'b0 || bus.d_valid !== 1'b0) begin bad++; $display("FAIL idle_rvalid_valid got=%h/%h exp=0/0", bus.i_valid, bus.d_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_rvalid_busy got=%h exp=0", bus.busy); end
    total++; if (bus.d_rdata !== 32'h0) begin bad++; $display("FAIL idle_rvalid_rdata got=%h exp=0", bus.d_rdata); end
  endtask

  task automatic test_single_load;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h100;
    #1;
    total++; if (bus.stall_d !== 1'b1) begin bad++; $display("FAIL load_c0_stall got=%h exp=1", bus.stall_d); end
    total++; if (bus.m_req !== 1'b0) begin bad++; $display("FAIL load_c0_mreq got=%h exp=0", bus.m_req); end
    tick(); // cycle 1
    total++; if (bus.m_req !== 1'b1) begin bad++; $display("FAIL load_c1_mreq got=%h exp=1", bus.m_req); end
    total++; if (bus.m_addr !== 32'h100) begin bad++; $display("FAIL load_c1_maddr got=%h exp=100", bus.m_addr); end
    total++; if (bus.m_we !== 1'b0) begin bad++; $display("FAIL load_c1_mwe got=%h exp=0", bus.m_we); end
    total++; if (bus.stall_d !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL load_c1_stall_busy got=%h/%h exp=1/1", bus.stall_d, bus.busy); end
    bus.m_gnt = 1'b1;
    tick(); // cycle 2
    bus.m_gnt = 1'b0;
    total++; if (bus.m_req !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL load_c2_mreq_busy got=%h/%h exp=0/1", bus.m_req, bus.busy); end
    total++; if (bus.stall_d !== 1'b1) begin bad++; $display("FAIL load_c2_stall got=%h exp=1", bus.stall_d); end
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'hDEADBEEF;
    tick(); // cycle 3
    bus.m_rvalid = 1'b0;
    total++; if (bus.d_valid !== 1'b1) begin bad++; $display("FAIL load_c3_dvalid got=%h exp=1", bus.d_valid); end
    total++; if (bus.d_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL load_c3_drdata got=%h exp=deadbeef", bus.d_rdata); end
    total++; if (bus.stall_d !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL load_c3_stall_busy got=%h/%h exp=0/0", bus.stall_d, bus.busy); end
    total++; if (bus.i_valid !== 1'b0) begin bad++; $display("FAIL load_c3_ivalid got=%h exp=0", bus.i_valid); end
    tick(); // cycle 4: d_req was still high in cycle 3, must not be re-granted
    bus.d_req = 1'b0;
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL load_c4_dvalid got=%h exp=0", bus.d_valid); end
    total++; if (bus.busy !== 1'b0 || bus.m_req !== 1'b0) begin bad++; $display("FAIL load_c4_dup_grant got=%h/%h exp=0/0", bus.busy, bus.m_req); end
    total++; if (bus.d_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL load_c4_hold got=%h exp=deadbeef", bus.d_rdata); end
    tick();
  endtask

  task automatic test_contention;
    resetn = 1'b0;
    tick();
    resetn = 1'b1; // cycle 0, last_d cleared
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h200;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h300;
    bus.d_wdata = 32'hAAAA5555;
    bus.d_be    = 4'hF;
    #1;
    total++; if (bus.stall_i !== 1'b1 || bus.stall_d !== 1'b1) begin bad++; $display("FAIL cont_c0_stall got=%h/%h exp=1/1", bus.stall_i, bus.stall_d); end
    tick(); // cycle 1
    total++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h300 || bus.m_we !== 1'b1) begin bad++; $display("FAIL cont_c1_dfirst got=%h/%h/%h exp=1/300/1", bus.m_req, bus.m_addr, bus.m_we); end
    total++; if (bus.m_wdata !== 32'hAAAA5555) begin bad++; $display("FAIL cont_c1_wdata got=%h exp=aaaa5555", bus.m_wdata); end
    bus.m_gnt = 1'b1;
    tick(); // cycle 2
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h0;
    tick(); // cycle 3
    bus.m_rvalid = 1'b0;
    total++; if (bus.d_valid !== 1'b1 || bus.i_valid !== 1'b0) begin bad++; $display("FAIL cont_c3_valid got=%h/%h exp=1/0", bus.d_valid, bus.i_valid); end
    total++; if (bus.stall_d !== 1'b0 || bus.stall_i !== 1'b1) begin bad++; $display("FAIL cont_c3_stall got=%h/%h exp=0/1", bus.stall_d, bus.stall_i); end
    tick(); // cycle 4: I granted during the d_valid cycle
    bus.d_req = 1'b0;
    total++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h200) begin bad++; $display("FAIL cont_c4_igrant got=%h/%h exp=1/200", bus.m_req, bus.m_addr); end
    total++; if (bus.m_we !== 1'b0 || bus.m_be !== 4'hF) begin bad++; $display("FAIL cont_c4_iforce got=%h/%h exp=0/f", bus.m_we, bus.m_be); end
    bus.m_gnt = 1'b1;
    tick(); // cycle 5
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h11223344;
    tick(); // cycle 6
    bus.m_rvalid = 1'b0;
    total++; if (bus.i_valid !== 1'b1 || bus.i_rdata !== 32'h11223344) begin bad++; $display("FAIL cont_c6_ivalid got=%h/%h exp=1/11223344", bus.i_valid, bus.i_rdata); end
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL cont_c6_dvalid got=%h exp=0", bus.d_valid); end
    tick(); // cycle 7: lone D load to leave last_d=1
    bus.i_req  = 1'b0;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h308;
    tick(); // cycle 8
    total++; if (bus.m_addr !== 32'h308) begin bad++; $display("FAIL cont_c8_maddr got=%h exp=308", bus.m_addr); end
    bus.m_gnt = 1'b1;
    tick();
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h55;
    tick(); // cycle 10: d_valid
    bus.m_rvalid = 1'b0;
    total++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h55) begin bad++; $display("FAIL cont_c10_dvalid got=%h/%h exp=1/55", bus.d_valid, bus.d_rdata); end
    tick(); // cycle 11: idle, last_d=1
    bus.d_req = 1'b0;
    tick(); // cycle 12: simultaneous again
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h20C;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h30C;
    tick(); // cycle 13
    total++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h20C) begin bad++; $display("FAIL cont_c13_ifirst got=%h/%h exp=1/20c", bus.m_req, bus.m_addr); end
    bus.m_gnt = 1'b1;
    tick();
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h66;
    tick(); // cycle 15
    bus.m_rvalid = 1'b0;
    total++; if (bus.i_valid !== 1'b1 || bus.i_rdata !== 32'h66) begin bad++; $display("FAIL cont_c15_ivalid got=%h/%h exp=1/66", bus.i_valid, bus.i_rdata); end
    tick(); // cycle 16
    bus.i_req = 1'b0;
    total++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h30C) begin bad++; $display("FAIL cont_c16_dsecond got=%h/%h exp=1/30c", bus.m_req, bus.m_addr); end
    bus.m_gnt = 1'b1;
    tick();
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h77;
    tick(); // cycle 18
    bus.m_rvalid = 1'b0;
    total++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h77) begin bad++; $display("FAIL cont_c18_dvalid got=%h/%h exp=1/77", bus.d_valid, bus.d_rdata); end
    total++; if (bus.i_rdata !== 32'h66) begin bad++; $display("FAIL cont_c18_ihold got=%h exp=66", bus.i_rdata); end
    tick();
    bus.d_req = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL cont_c19_busy got=%h exp=0", bus.busy); end
    tick();
  endtask

  task automatic test_backpressure;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h400;
    bus.d_wdata = 32'h12345678;
    bus.d_be    = 4'b0011;
    tick(); // cycle 1
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h400 || bus.m_wdata !== 32'h12345678 || bus.m_be !== 4'b0011 || bus.m_we !== 1'b1)
        begin bad++; $display("FAIL bp_hold%0d got=%h/%h/%h/%h/%h exp=1/400/12345678/3/1", k, bus.m_req, bus.m_addr, bus.m_wdata, bus.m_be, bus.m_we); end
      total++; if (bus.d_valid !== 1'b0 || bus.stall_d !== 1'b1) begin bad++; $display("FAIL bp_wait%0d got=%h/%h exp=0/1", k, bus.d_valid, bus.stall_d); end
      tick();
    end
    // cycle 5: grant finally given
    total++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h400) begin bad++; $display("FAIL bp_c5_mreq got=%h/%h exp=1/400", bus.m_req, bus.m_addr); end
    bus.m_gnt = 1'b1;
    tick(); // cycle 6
    bus.m_gnt = 1'b0;
    total++; if (bus.m_req !== 1'b0) begin bad++; $display("FAIL bp_c6_mreq got=%h exp=0", bus.m_req); end
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h0;
    tick(); // cycle 7
    bus.m_rvalid = 1'b0;
    total++; if (bus.d_valid !== 1'b1 || bus.stall_d !== 1'b0) begin bad++; $display("FAIL bp_c7_dvalid got=%h/%h exp=1/0", bus.d_valid, bus.stall_d); end
    tick();
    bus.d_req = 1'b0;
    tick();
  endtask

  task automatic test_killed_fetch;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h500;
    tick(); // cycle 1
    total++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h500) begin bad++; $display("FAIL kill_c1_mreq got=%h/%h exp=1/500", bus.m_req, bus.m_addr); end
    bus.m_gnt = 1'b1;
    tick(); // cycle 2: WAIT, fetch killed
    bus.m_gnt = 1'b0;
    bus.i_req = 1'b0;
    #1;
    total++; if (bus.stall_i !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL kill_c2_stall_busy got=%h/%h exp=0/1", bus.stall_i, bus.busy); end
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'hCAFEF00D;
    tick(); // cycle 3
    bus.m_rvalid = 1'b0;
    total++; if (bus.i_valid !== 1'b1 || bus.i_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL kill_c3_ivalid got=%h/%h exp=1/cafef00d", bus.i_valid, bus.i_rdata); end
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h600;
    tick(); // cycle 4
    total++; if (bus.i_valid !== 1'b0) begin bad++; $display("FAIL kill_c4_once got=%h exp=0", bus.i_valid); end
    total++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h600) begin bad++; $display("FAIL kill_c4_dgrant got=%h/%h exp=1/600", bus.m_req, bus.m_addr); end
    bus.m_gnt = 1'b1;
    tick();
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h600D;
    tick(); // cycle 6
    bus.m_rvalid = 1'b0;
    total++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h600D) begin bad++; $display("FAIL kill_c6_dvalid got=%h/%h exp=1/600d", bus.d_valid, bus.d_rdata); end
    tick();
    bus.d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h700;
    tick(); // cycle 1
    bus.m_gnt = 1'b1;
    tick(); // cycle 2: WAIT
    bus.m_gnt = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rmid_c2_busy got=%h exp=1", bus.busy); end
    resetn = 1'b0;
    tick(); // cycle 3
    resetn    = 1'b1;
    bus.d_req = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.m_req !== 1'b0 || bus.m_addr !== 32'h0) begin bad++; $display("FAIL rmid_c3_state got=%h/%h/%h exp=0/0/0", bus.busy, bus.m_req, bus.m_addr); end
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'hBAD;
    tick(); // cycle 4
    bus.m_rvalid = 1'b0;
    total++; if (bus.d_valid !== 1'b0 || bus.i_valid !== 1'b0) begin bad++; $display("FAIL rmid_c4_valid got=%h/%h exp=0/0", bus.d_valid, bus.i_valid); end
    total++; if (bus.d_rdata !== 32'h0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_c4_rdata_busy got=%h/%h exp=0/0", bus.d_rdata, bus.busy); end
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h800;
    tick(); // cycle 5
    total++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h800) begin bad++; $display("FAIL rmid_c5_mreq got=%h/%h exp=1/800", bus.m_req, bus.m_addr); end
    bus.m_gnt = 1'b1;
    tick();
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h99;
    tick(); // cycle 7
    bus.m_rvalid = 1'b0;
    total++; if (bus.i_valid !== 1'b1 || bus.i_rdata !== 32'h99) begin bad++; $display("FAIL rmid_c7_ivalid got=%h/%h exp=1/99", bus.i_valid, bus.i_rdata); end
    tick();
    bus.i_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_contention();
    test_backpressure();
    test_killed_fetch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the fetch stage (I-side, read-only) and the memory stage (D-side, read/write) of the pipelined MIPS core. It owns the one backend memory port and runs one transaction at a time. It returns read data and a one-cycle completion pulse to the winning stage. It also drives per-stage stall requests that the hazard unit ORs into `stallF` and `stallD`.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; byte-enable width is `DW/8`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `i_req`  in  1  fetch request; held until `i_valid`.
- `i_addr`  in  AW  fetch address.
- `i_rdata`  out  DW  fetched word; valid with `i_valid`.
- `i_valid`  out  1  one-cycle completion pulse.
- `d_req`  in  1  data request; held until `d_valid`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  store data.
- `d_be`  in  DW/8  store byte enables.
- `d_rdata`  out  DW  load data; valid with `d_valid`.
- `d_valid`  out  1  one-cycle completion pulse (load or store).
- `stall_i`  out  1  `i_req & ~i_valid`; combinational.
- `stall_d`  out  1  `d_req & ~d_valid`; combinational.
- `m_req`  out  1  backend request; held until `m_gnt`.
- `m_we`, `m_addr`, `m_wdata`, `m_be`  out  1/AW/DW/DW/8  registered copy of the granted request.
- `m_gnt`  in  1  backend accepts the request while `m_req` is high.
- `m_rvalid`  in  1  backend response (load data or store ack), ≥1 cycle after `m_gnt`.
- `m_rdata`  in  DW  backend load data.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM has three states:
  - IDLE: arbitrate.
  - REQ: `m_req`=1, wait for `m_gnt`.
  - WAIT: wait for `m_rvalid`.
- IDLE to REQ on a grant. The granted request's `we/addr/wdata/be` are latched into the `m_*` registers. Owner flag `own_d` is set (1 = D). I-side grants force `m_we`=0 and `m_be`=all-ones.
- REQ to WAIT when `m_gnt`=1. `m_*` hold stable throughout REQ.
- WAIT to IDLE when `m_rvalid`=1:
  - `m_rdata` is registered into `d_rdata` or `i_rdata` according to `own_d`.
  - The matching `x_valid` is pulsed for the next cycle.
  - `x_rdata` holds its value until that side's next completion.
- Arbitration in IDLE:
  - D wins by default.
  - I wins if both sides are requesting and the last completed transaction was D (`last_d`=1). Back-to-back stores therefore cannot starve fetch.
  - `last_d` updates on every completion.
- A requester whose `x_valid` is high in the current cycle is excluded from arbitration that cycle, because its `req` is still asserted for that one cycle. No duplicate grant is allowed.
- Once granted, a transaction always runs to completion. If `x_req` drops mid-transaction (e.g. a fetch killed by a branch), `x_valid` still pulses and the stage discards it.
- `m_rvalid` or `m_gnt` arriving in IDLE is ignored.

## Timing
- Reset (`resetn`=0 at an edge) forces:
  - state=IDLE, `m_req`=0, `i_valid`=`d_valid`=0, `last_d`=0;
  - `i_rdata`=`d_rdata`=0, `m_addr/m_wdata/m_we/m_be`=0.
  - A reset mid-transaction abandons the transaction; a late `m_rvalid` after reset is ignored.
- Latency with a zero-wait backend (`m_gnt` high in the first REQ cycle, `m_rvalid` the next cycle):
  - `x_req` rises in cycle 0;
  - `m_req` is high in cycle 1;
  - WAIT in cycle 2, with `m_rvalid`;
  - `x_valid` in cycle 3.
  - Total: 3 cycles; each backend wait cycle adds 1.
- Throughput: at most one transaction per 3 cycles. A new grant is possible in the same cycle `x_valid` is high (the other side only).
- `stall_i`/`stall_d` are high from the `req` cycle through the cycle before `x_valid`, and low in the `x_valid` cycle.
- `m_*` outputs are registered. `stall_*` are the only combinational paths (from `x_req` and registered `x_valid`).

## Test plan
- Reset/idle: hold `resetn`=0 2 cycles, release → all outputs 0, `busy`=0. `m_rvalid` pulse in IDLE → no `x_valid`.
- Single load: `d_req`=1, `d_we`=0, `d_addr`=0x100, zero-wait backend returning 0xDEADBEEF → `m_req` in cycle 1 with `m_addr`=0x100; `d_valid` in cycle 3 with `d_rdata`=0xDEADBEEF; `stall_d` high in cycles 0–2.
- Contention: `i_req` and `d_req` both rise in cycle 0 → D granted first. I is granted in the `d_valid` cycle (`last_d`=1), and `i_valid` arrives 3 cycles later. A repeated simultaneous D request then also yields I-before-D.
- Backpressure: `m_gnt` withheld 4 cycles → `m_req`/`m_addr`/`m_wdata` stable throughout. A store with `d_be`=4'b0011 and `d_wdata`=0x12345678 appears unchanged on `m_*`. `d_valid` arrives 4 cycles later than the zero-wait case.
- Killed fetch: `i_req` drops in WAIT → `i_valid` still pulses once, and the subsequent `d_req` is granted the cycle `i_valid` is high.
- Reset mid-transaction: `resetn`=0 during WAIT, then `m_rvalid` arrives after release → no `x_valid`, state IDLE, next request served normally.
